// File: rtl/sysid_probe_pkg.sv
// sysid_probe_pkg
//   Shared definitions for the system-ID probe master:
//     state_t      - probe FSM state encoding
//     ADDR_ID      - word address of the sysid ID register
//     ADDR_TS      - word address of the sysid timestamp register
//     STALL_CNT_W  - width of the waitrequest stall counter
package sysid_probe_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam int unsigned STALL_CNT_W = 16;

endpackage : sysid_probe_pkg

// File: rtl/sysid_probe_stall_cnt.sv
// sysid_probe_stall_cnt
//   Counts cycles in which a read is stalled by waitrequest and flags when
//   the count has reached the programmed limit.
//   Ports:
//     clock   - system clock
//     clear   - synchronous clear (also used as the reset path)
//     enable  - count this cycle (read asserted and slave stalling)
//     limit   - stall count at which expired asserts
//     expired - count has reached limit
module sysid_probe_stall_cnt
    import sysid_probe_pkg::*;
(
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [STALL_CNT_W-1:0] limit,
    output logic                   expired
);

    logic [STALL_CNT_W-1:0] count_q;

    assign expired = (count_q >= limit);

    // Counting stops once expired so the value can never wrap back below
    // the limit while the owner is still reacting to it.
    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule : sysid_probe_stall_cnt

// File: rtl/sysid_probe_master.sv
// sysid_probe_master
//   Boot-time sanity checker. On a start pulse it reads the sysid slave's
//   ID word (address 0) and timestamp word (address 1) over Avalon-MM
//   (no pipelining, zero fixed latency) and compares them with the values
//   software was built against. Results hold until the next start or reset.
//
//   Optional feature macro: SYSID_PROBE_TIMEOUT_EN
//     defined   - a stalled read is abandoned after TIMEOUT_CYCLES stall
//                 cycles; timeout is reported and both ok bits forced low.
//     undefined - no stall counter; reads wait on waitrequest forever and
//                 timeout is constant 0.
//
//   Ports:
//     clock, reset     - single clock, synchronous active-high reset
//     start            - one-cycle check request, ignored while busy
//     avm_address      - word address to the sysid slave
//     avm_read         - read strobe
//     avm_readdata     - read data, valid when read=1 and waitrequest=0
//     avm_waitrequest  - slave stall
//     busy             - check in progress (RD_ID, RD_TS, CHECK)
//     done             - results valid
//     id_ok / ts_ok    - captured words match the expected values
//     timeout          - a read stalled past TIMEOUT_CYCLES
//     id_value         - captured ID word
//     ts_value         - captured timestamp word
module sysid_probe_master
    import sysid_probe_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1543892682,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sysid_probe_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t state_q;
    state_t state_d;
    logic   stall_expired;
    logic   read_phase;

    // ------------------------------------------------------------------
    // Stall watchdog
    // ------------------------------------------------------------------
`ifdef SYSID_PROBE_TIMEOUT_EN
    localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(TIMEOUT_CYCLES);

    logic stall_clear;
    logic stall_enable;

    // Any state change restarts the count, so each read gets its own budget.
    assign stall_clear  = reset || (state_q != state_d);
    assign stall_enable = avm_read && avm_waitrequest;

    sysid_probe_stall_cnt u_stall_cnt (
        .clock   (clock),
        .clear   (stall_clear),
        .enable  (stall_enable),
        .limit   (STALL_LIMIT),
        .expired (stall_expired)
    );
`else
    assign stall_expired = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = RD_ID;
            end
            RD_ID: begin
                if (stall_expired)         state_d = DONE;
                else if (!avm_waitrequest) state_d = RD_TS;
            end
            RD_TS: begin
                if (stall_expired)         state_d = DONE;
                else if (!avm_waitrequest) state_d = CHECK;
            end
            CHECK: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        read_phase  = (state_q == RD_ID) || (state_q == RD_TS);
        // The strobe drops in the cycle the stall budget runs out so the
        // abandoned read can never be accepted late.
        avm_read    = read_phase && !stall_expired;
        avm_address = (state_q == RD_TS) ? ADDR_TS : ADDR_ID;
        busy        = read_phase || (state_q == CHECK);
        done        = (state_q == DONE);
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        id_ok    <= 1'b0;
                        ts_ok    <= 1'b0;
                        timeout  <= 1'b0;
                        id_value <= '0;
                        ts_value <= '0;
                    end
                end
                RD_ID: begin
                    if (stall_expired) begin
                        timeout <= 1'b1;
                        id_ok   <= 1'b0;
                        ts_ok   <= 1'b0;
                    end else if (!avm_waitrequest) begin
                        id_value <= avm_readdata;
                    end
                end
                RD_TS: begin
                    if (stall_expired) begin
                        timeout <= 1'b1;
                        id_ok   <= 1'b0;
                        ts_ok   <= 1'b0;
                    end else if (!avm_waitrequest) begin
                        ts_value <= avm_readdata;
                    end
                end
                CHECK: begin
                    id_ok <= (id_value == EXPECTED_ID);
                    ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
                end
                default: begin
                end
            endcase
        end
    end

endmodule : sysid_probe_master

// File: tb/tb_sysid_probe_master.sv
// Scoreboard bench for sysid_probe_master. Each accepted start pushes the
// expected result; a monitor pops and compares on every rising edge of done.
module tb_sysid_probe_master;

    localparam int unsigned TMO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    sysid_probe_master #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (32'd1543892682),
        .TIMEOUT_CYCLES     (TMO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Sysid slave model
    // ------------------------------------------------------------------
    logic [31:0] id_word  = 32'd0;
    logic [31:0] ts_word  = 32'd1543892682;
    int          stall_id = 0;
    int          stall_ts = 0;
    bit          stuck_ts = 1'b0;
    int          wcnt     = 0;

    assign avm_readdata    = avm_address ? ts_word : id_word;
    assign avm_waitrequest = avm_read &&
                             (avm_address ? (stuck_ts || (wcnt < stall_ts)) : (wcnt < stall_id));

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Scoreboard and monitor
    // ------------------------------------------------------------------
    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];
    int   runs_seen   = 0;
    int   runs_pushed = 0;
    logic done_prev   = 1'b0;

    bit   check_stable = 1'b0;
    logic prev_stall   = 1'b0;
    logic prev_addr    = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            done_prev  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (done && !done_prev) begin
                runs_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("id_ok",    32'(id_ok),   32'(e.id_ok));
                    check("ts_ok",    32'(ts_ok),   32'(e.ts_ok));
                    check("timeout",  32'(timeout), 32'(e.tmo));
                    check("id_value", id_value,     e.idv);
                    check("ts_value", ts_value,     e.tsv);
                    check("latency",  32'(cyc + 1 - e.start_cyc), 32'(e.lat));
                    check("read_in_done", 32'(avm_read), 32'd0);
                end
            end
            done_prev = done;

            if (check_stable && prev_stall) begin
                check("stall_read_stable", 32'(avm_read),    32'd1);
                check("stall_addr_stable", 32'(avm_address), 32'(prev_addr));
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic pulse_start(output int sc);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        sc = cyc;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_wait_timeout actual=0 required=1");
        end
    endtask

    task automatic run(input logic [31:0] idw, input logic [31:0] tsw,
                       input int sid, input int sts, input bit stuck, input exp_t e_in);
        exp_t e;
        int   sc;
        e        = e_in;
        id_word  = idw;
        ts_word  = tsw;
        stall_id = sid;
        stall_ts = sts;
        stuck_ts = stuck;
        pulse_start(sc);
        e.start_cyc = sc;
        sb.push_back(e);
        runs_pushed++;
        check("done_clear_on_start", 32'(done), 32'd0);
        check("busy_after_start",    32'(busy), 32'd1);
        wait_done(e.lat + 10);
        @(negedge clock);
    endtask

    initial begin
        exp_t e;
        int   sc;

        repeat (3) @(posedge clock);
        #1;
        check("rst_avm_read", 32'(avm_read),    32'd0);
        check("rst_address",  32'(avm_address), 32'd0);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_done",     32'(done),        32'd0);
        check("rst_id_ok",    32'(id_ok),       32'd0);
        check("rst_ts_ok",    32'(ts_ok),       32'd0);
        check("rst_timeout",  32'(timeout),     32'd0);
        check("rst_id_value", id_value,         32'd0);
        check("rst_ts_value", ts_value,         32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Zero-wait, matching image
        e = '{id_ok: 1'b1, ts_ok: 1'b1, tmo: 1'b0, idv: 32'd0, tsv: 32'd1543892682, lat: 4, start_cyc: 0};
        run(32'd0, 32'd1543892682, 0, 0, 1'b0, e);

        // Timestamp off by one, restart straight from DONE
        e = '{id_ok: 1'b1, ts_ok: 1'b0, tmo: 1'b0, idv: 32'd0, tsv: 32'd1543892683, lat: 4, start_cyc: 0};
        run(32'd0, 32'd1543892683, 0, 0, 1'b0, e);

        // Three wait states on each read
        check_stable = 1'b1;
        e = '{id_ok: 1'b1, ts_ok: 1'b1, tmo: 1'b0, idv: 32'd0, tsv: 32'd1543892682, lat: 10, start_cyc: 0};
        run(32'd0, 32'd1543892682, 3, 3, 1'b0, e);
        check_stable = 1'b0;

        // Wrong ID, right timestamp
        e = '{id_ok: 1'b0, ts_ok: 1'b1, tmo: 1'b0, idv: 32'hDEAD_BEEF, tsv: 32'd1543892682, lat: 4, start_cyc: 0};
        run(32'hDEAD_BEEF, 32'd1543892682, 0, 0, 1'b0, e);

`ifdef SYSID_PROBE_TIMEOUT_EN
        // Timestamp read stuck: abandoned after TMO stall cycles
        e = '{id_ok: 1'b0, ts_ok: 1'b0, tmo: 1'b1, idv: 32'd0, tsv: 32'd0, lat: 2 + TMO + 1, start_cyc: 0};
        run(32'd0, 32'd1543892682, 0, 0, 1'b1, e);
`else
        // Long stall well past TMO: without the watchdog the read still completes
        e = '{id_ok: 1'b1, ts_ok: 1'b1, tmo: 1'b0, idv: 32'd0, tsv: 32'd1543892682, lat: 24, start_cyc: 0};
        run(32'd0, 32'd1543892682, 0, 20, 1'b0, e);
`endif

        // Start while busy is ignored
        id_word  = 32'd0;
        ts_word  = 32'd1543892682;
        stall_id = 2;
        stall_ts = 2;
        stuck_ts = 1'b0;
        e = '{id_ok: 1'b1, ts_ok: 1'b1, tmo: 1'b0, idv: 32'd0, tsv: 32'd1543892682, lat: 8, start_cyc: 0};
        pulse_start(sc);
        e.start_cyc = sc;
        sb.push_back(e);
        runs_pushed++;
        @(posedge clock);
        #1;
        pulse_start(sc);
        wait_done(20);
        repeat (12) @(posedge clock);
        #1;
        check("done_held",        32'(done),      32'd1);
        check("runs_seen",        32'(runs_seen), 32'(runs_pushed));

        // Reset while in RD_TS
        id_word  = 32'h1234_5678;
        stall_id = 0;
        stall_ts = 50;
        begin
            bit in_ts = 1'b0;
            pulse_start(sc);
            for (int k = 0; k < 20; k++) begin
                if (avm_read && avm_address) begin
                    in_ts = 1'b1;
                    break;
                end
                @(posedge clock);
                #1;
            end
            check("reached_rd_ts", 32'(in_ts), 32'd1);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_avm_read", 32'(avm_read),    32'd0);
        check("mid_rst_address",  32'(avm_address), 32'd0);
        check("mid_rst_busy",     32'(busy),        32'd0);
        check("mid_rst_done",     32'(done),        32'd0);
        check("mid_rst_id_value", id_value,         32'd0);
        check("mid_rst_ts_value", ts_value,         32'd0);
        check("mid_rst_ok_bits",  32'({id_ok, ts_ok, timeout}), 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("idle_after_reset", 32'({busy, done, avm_read}), 32'd0);
        check("scoreboard_empty", 32'(sb.size()),              32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sysid_probe_master
